// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word read or byte-masked write, LAT wait states,
// valid/ready response. Optional address range checking via DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] cnt;

  logic             hold_write;
  logic             hold_oor;
  logic [IDX_W-1:0] hold_idx;
  logic [31:0]      hold_wdata;
  logic [3:0]       hold_wstrb;

  logic [31:0]      mem [DEPTH];

  logic             accept_c;
  logic             access_c;
  logic             req_oor_c;
  logic [IDX_W-1:0] req_idx_c;
  logic             acc_write_c;
  logic             acc_oor_c;
  logic [IDX_W-1:0] acc_idx_c;
  logic [31:0]      acc_wdata_c;
  logic [3:0]       acc_wstrb_c;
  logic             unused_addr;

  assign req_idx_c   = req_addr[2 +: IDX_W];
  assign unused_addr = ^req_addr;

`ifdef DMEM_RANGE_CHECK_EN
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(DEPTH * 4);
  assign req_oor_c = ({1'b0, req_addr} >= LIMIT);
`else
  assign req_oor_c = 1'b0;
`endif

  // With LAT=0 the access happens on the acceptance edge, so use the live request.
  assign acc_write_c = (state == IDLE) ? req_write : hold_write;
  assign acc_oor_c   = (state == IDLE) ? req_oor_c : hold_oor;
  assign acc_idx_c   = (state == IDLE) ? req_idx_c : hold_idx;
  assign acc_wdata_c = (state == IDLE) ? req_wdata : hold_wdata;
  assign acc_wstrb_c = (state == IDLE) ? req_wstrb : hold_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    access_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (LAT == 0) begin
            access_c   = ~rst;
            next_state = RESP;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          access_c   = ~rst;
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cnt        <= '0;
      hold_write <= 1'b0;
      hold_oor   <= 1'b0;
      hold_idx   <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
    end else begin
      req_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == RESP);
      if (accept_c) begin
        hold_write <= req_write;
        hold_oor   <= req_oor_c;
        hold_idx   <= req_idx_c;
        hold_wdata <= req_wdata;
        hold_wstrb <= req_wstrb;
        cnt        <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access_c) begin
        rsp_rdata <= (acc_write_c || acc_oor_c) ? 32'h0 : mem[acc_idx_c];
        rsp_err   <= acc_oor_c;
      end
    end
  end

  // Storage is not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (access_c && acc_write_c && !acc_oor_c) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb_c[i]) mem[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
      end
    end
  end

endmodule
